// File: rtl/color_analyzer_p_if.sv
// Frame-buffer read port and result bus of the colour analyzer.
// master = analyzer side, slave = frame buffer / controller side.
interface color_analyzer_p_if #(
  parameter int AW = 15,
  parameter int DW = 8,
  parameter int SW = 20
);
  logic          init;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          busy;
  logic          done;
  logic [2:0]    valor;
  logic [SW-1:0] sum_r;
  logic [SW-1:0] sum_g;
  logic [SW-1:0] sum_b;

  modport master (
    input  init, data,
    output addr, busy, done, valor, sum_r, sum_g, sum_b
  );

  modport slave (
    output init, data,
    input  addr, busy, done, valor, sum_r, sum_g, sum_b
  );
endinterface

// File: rtl/color_analyzer_p.sv
// Scans a frame buffer once per start edge, sums the R/G/B channels and
// reports which channel dominates the image.
module color_analyzer_p #(
  parameter int            AW        = 15,
  parameter int            NPIX      = 19200,
  parameter int            BASE_ADDR = 0,
  parameter logic [AW-1:0] PARK_ADDR = '1,
  parameter int            MODE      = 0,
  parameter int            RD_LAT    = 1,
  parameter int            MARGIN    = 0,
  parameter int            SW        = 20
) (
  input  logic              clk,
  input  logic              rst,
  color_analyzer_p_if.master bus
);

  localparam int DW = (MODE == 1) ? 12 : 8;
  localparam int CW = $clog2(NPIX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DECIDE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [RD_LAT-1:0] vpipe;
  logic              init_q;
  logic [SW-1:0]     acc_r, acc_g, acc_b;
  logic [DW-1:0]     pix;
  logic [3:0]        ch_r, ch_g, ch_b;
  logic [SW:0]       xr, xg, xb, xm;
  logic [2:0]        verdict;

  assign pix = bus.data;

  if (MODE == 1) begin : g_rgb444
    assign ch_r = pix[11:8];
    assign ch_g = pix[7:4];
    assign ch_b = pix[3:0];
  end else begin : g_rgb332
    assign ch_r = {1'b0, pix[7:5]};
    assign ch_g = {1'b0, pix[4:2]};
    assign ch_b = {1'b0, pix[1:0], 1'b0};
  end

  // One extra bit so that sum + MARGIN can never wrap during the compare.
  assign xr = {1'b0, acc_r};
  assign xg = {1'b0, acc_g};
  assign xb = {1'b0, acc_b};
  assign xm = (SW+1)'(MARGIN);

  // NOTE: every branch assigns verdict, so no latch can be inferred.
  always_comb begin
    if (acc_r == '0 && acc_g == '0 && acc_b == '0)  verdict = 3'b000;
    else if (xr > xg + xm && xr > xb + xm)          verdict = 3'b100;
    else if (xg > xr + xm && xg > xb + xm)          verdict = 3'b010;
    else if (xb > xr + xm && xb > xg + xm)          verdict = 3'b001;
    else                                            verdict = 3'b111;
  end

  // NOTE: reset is synchronous, so it is just the first branch of the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      vpipe    <= '0;
      init_q   <= 1'b0;
      acc_r    <= '0;
      acc_g    <= '0;
      acc_b    <= '0;
      bus.addr <= PARK_ADDR;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.valor <= 3'b000;
      bus.sum_r <= '0;
      bus.sum_g <= '0;
      bus.sum_b <= '0;
    end else begin
      init_q <= bus.init;
      // Tag travels alongside each issued address until its data returns.
      vpipe  <= (vpipe << 1) | RD_LAT'(state == ISSUE);
      if (vpipe[RD_LAT-1]) begin
        acc_r <= acc_r + SW'(ch_r);
        acc_g <= acc_g + SW'(ch_g);
        acc_b <= acc_b + SW'(ch_b);
      end

      case (state)
        IDLE: begin
          if (bus.init && !init_q) begin
            state    <= ISSUE;
            cnt      <= '0;
            acc_r    <= '0;
            acc_g    <= '0;
            acc_b    <= '0;
            bus.addr <= AW'(BASE_ADDR);
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
          end
        end
        ISSUE: begin
          if (cnt == CW'(NPIX - 1)) begin
            state    <= DRAIN;
            cnt      <= '0;
            bus.addr <= PARK_ADDR;
          end else begin
            cnt      <= cnt + 1'b1;
            bus.addr <= bus.addr + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == CW'(RD_LAT - 1)) state <= DECIDE;
          else                        cnt   <= cnt + 1'b1;
        end
        DECIDE: begin
          bus.sum_r <= acc_r;
          bus.sum_g <= acc_g;
          bus.sum_b <= acc_b;
          bus.valor <= verdict;
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          bus.addr  <= PARK_ADDR;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_analyzer_p.sv
// Runs two analyzer configurations side by side (RGB332/latency 1 and
// RGB444/latency 3) against an arithmetic model of channel sums and dominance.
module tb_color_analyzer_p;

  localparam int            AW       = 15;
  localparam int            NPIX     = 16;
  localparam int            SW       = 20;
  localparam int            BASE_A   = 0;
  localparam int            BASE_B   = 40;
  localparam logic [AW-1:0] PARK_A   = '1;
  localparam logic [AW-1:0] PARK_B   = 15'h1234;
  localparam int            LAT_A    = 1;
  localparam int            LAT_B    = 3;
  localparam int            MARGIN_A = 0;
  localparam int            MARGIN_B = 10;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic init = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int prev_a[3];
  int prev_b[3];

  color_analyzer_p_if #(.AW(AW), .DW(8),  .SW(SW)) bus_a ();
  color_analyzer_p_if #(.AW(AW), .DW(12), .SW(SW)) bus_b ();

  color_analyzer_p #(
    .AW(AW), .NPIX(NPIX), .BASE_ADDR(BASE_A), .PARK_ADDR(PARK_A),
    .MODE(0), .RD_LAT(LAT_A), .MARGIN(MARGIN_A), .SW(SW)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  color_analyzer_p #(
    .AW(AW), .NPIX(NPIX), .BASE_ADDR(BASE_B), .PARK_ADDR(PARK_B),
    .MODE(1), .RD_LAT(LAT_B), .MARGIN(MARGIN_B), .SW(SW)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Frame buffers: reads outside the scan window return all-ones garbage.
  logic [7:0]  pix_a [NPIX];
  logic [11:0] pix_b [NPIX];
  logic [7:0]  rd_a;
  logic [11:0] rd_b [LAT_B];

  assign bus_a.init = init;
  assign bus_b.init = init;
  assign bus_a.data = rd_a;
  assign bus_b.data = rd_b[LAT_B-1];

  always @(posedge clk) begin
    rd_a <= (int'(bus_a.addr) >= BASE_A && int'(bus_a.addr) < BASE_A + NPIX)
            ? pix_a[int'(bus_a.addr) - BASE_A] : 8'hFF;
    rd_b[0] <= (int'(bus_b.addr) >= BASE_B && int'(bus_b.addr) < BASE_B + NPIX)
               ? pix_b[int'(bus_b.addr) - BASE_B] : 12'hFFF;
    for (int i = 1; i < LAT_B; i++) rd_b[i] <= rd_b[i-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Channel value c (0=R,1=G,2=B) of pixel p, straight from the pixel formats.
  function automatic int chan(input int mode, input int p, input int c);
    if (mode == 0) begin
      case (c)
        0:       return p / 32;
        1:       return (p / 4) % 8;
        default: return (p % 4) * 2;
      endcase
    end else begin
      case (c)
        0:       return p / 256;
        1:       return (p / 16) % 16;
        default: return p % 16;
      endcase
    end
  endfunction

  function automatic int dominance(input int r, input int g, input int b, input int m);
    if (r + g + b == 0)       return 0;
    if (r > g + m && r > b + m) return 4;
    if (g > r + m && g > b + m) return 2;
    if (b > r + m && b > g + m) return 1;
    return 7;
  endfunction

  task automatic fill_directed(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0: begin pix_a[i] = 8'hE0; pix_b[i] = 12'hF00; end
        1: begin pix_a[i] = 8'h03; pix_b[i] = 12'h880; end
        2: begin pix_a[i] = 8'h1C; pix_b[i] = 12'(i); end
        3: begin pix_a[i] = 8'h00; pix_b[i] = 12'h000; end
        default: begin
          pix_a[i] = (i % 2 == 0) ? 8'hE0 : 8'h1C;
          pix_b[i] = (i % 2 == 0) ? 12'hF00 : 12'h0F0;
        end
      endcase
    end
  endtask

  task automatic fill_random();
    logic [7:0]  ma;
    logic [11:0] mb;
    case ($urandom_range(0, 3))
      0: begin ma = 8'hE3; mb = 12'hF0F; end
      1: begin ma = 8'h1F; mb = 12'h0FF; end
      2: begin ma = 8'hFC; mb = 12'hFF0; end
      default: begin ma = 8'hFF; mb = 12'hFFF; end
    endcase
    for (int i = 0; i < NPIX; i++) begin
      pix_a[i] = 8'($urandom) & ma;
      pix_b[i] = 12'($urandom) & mb;
    end
  endtask

  // One full scan with init held high throughout (optionally re-pulsed mid-scan).
  task automatic run_scan(input bit repulse);
    int ea[3];
    int eb[3];
    int da, db, aerr_a, aerr_b;
    ea = '{0, 0, 0};
    eb = '{0, 0, 0};
    for (int i = 0; i < NPIX; i++)
      for (int c = 0; c < 3; c++) begin
        ea[c] += chan(0, int'(pix_a[i]), c);
        eb[c] += chan(1, int'(pix_b[i]), c);
      end
    da = -1; db = -1; aerr_a = 0; aerr_b = 0;
    @(negedge clk) init = 1'b1;
    for (int n = 1; n <= NPIX + 12; n++) begin
      @(negedge clk);
      if (n <= NPIX) begin
        if (bus_a.addr !== AW'(BASE_A + n - 1)) aerr_a++;
        if (bus_b.addr !== AW'(BASE_B + n - 1)) aerr_b++;
      end
      if (n == 2) begin
        check("hold_sum_r_a", 32'(bus_a.sum_r), 32'(prev_a[0]));
        check("hold_sum_g_b", 32'(bus_b.sum_g), 32'(prev_b[1]));
        check("busy_a", 32'(bus_a.busy), 32'd1);
        check("done_clr_b", 32'(bus_b.done), 32'd0);
      end
      if (repulse && n == 4) init = 1'b0;
      if (repulse && n == 5) init = 1'b1;
      if (bus_a.done === 1'b1 && da < 0) da = n;
      if (bus_b.done === 1'b1 && db < 0) db = n;
    end
    check("done_cycle_a", 32'(da), 32'(NPIX + LAT_A + 2));
    check("done_cycle_b", 32'(db), 32'(NPIX + LAT_B + 2));
    check("addr_seq_a", 32'(aerr_a), 32'd0);
    check("addr_seq_b", 32'(aerr_b), 32'd0);
    check("park_a", 32'(bus_a.addr), 32'(PARK_A));
    check("park_b", 32'(bus_b.addr), 32'(PARK_B));
    check("single_scan_a", 32'(bus_a.busy), 32'd0);
    check("single_scan_b", 32'(bus_b.busy), 32'd0);
    check("sum_r_a", 32'(bus_a.sum_r), 32'(ea[0]));
    check("sum_g_a", 32'(bus_a.sum_g), 32'(ea[1]));
    check("sum_b_a", 32'(bus_a.sum_b), 32'(ea[2]));
    check("valor_a", 32'(bus_a.valor), 32'(dominance(ea[0], ea[1], ea[2], MARGIN_A)));
    check("sum_r_b", 32'(bus_b.sum_r), 32'(eb[0]));
    check("sum_g_b", 32'(bus_b.sum_g), 32'(eb[1]));
    check("sum_b_b", 32'(bus_b.sum_b), 32'(eb[2]));
    check("valor_b", 32'(bus_b.valor), 32'(dominance(eb[0], eb[1], eb[2], MARGIN_B)));
    prev_a = ea;
    prev_b = eb;
    init = 1'b0;
  endtask

  task automatic check_cleared(input string phase);
    check({phase, "_busy_a"},  32'(bus_a.busy),  32'd0);
    check({phase, "_done_a"},  32'(bus_a.done),  32'd0);
    check({phase, "_valor_a"}, 32'(bus_a.valor), 32'd0);
    check({phase, "_sum_r_a"}, 32'(bus_a.sum_r), 32'd0);
    check({phase, "_addr_a"},  32'(bus_a.addr),  32'(PARK_A));
    check({phase, "_busy_b"},  32'(bus_b.busy),  32'd0);
    check({phase, "_done_b"},  32'(bus_b.done),  32'd0);
    check({phase, "_sum_b_b"}, 32'(bus_b.sum_b), 32'd0);
    check({phase, "_addr_b"},  32'(bus_b.addr),  32'(PARK_B));
  endtask

  initial begin
    int saw;
    prev_a = '{0, 0, 0};
    prev_b = '{0, 0, 0};
    for (int i = 0; i < NPIX; i++) begin pix_a[i] = '0; pix_b[i] = '0; end

    // Reset held together with init: the start must not be taken.
    rst  = 1'b1;
    init = 1'b1;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    init = 1'b0;
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      fill_directed(k);
      run_scan(1'b0);
    end

    for (int k = 0; k < 8; k++) begin
      fill_random();
      run_scan(k == 3);
    end

    // Abort mid-scan: no result may ever appear from the aborted scan.
    fill_random();
    @(negedge clk) init = 1'b1;
    repeat (5) @(negedge clk);
    rst  = 1'b1;
    init = 1'b0;
    @(negedge clk);
    check_cleared("abort");
    rst = 1'b0;
    saw = 0;
    repeat (NPIX + 10) begin
      @(negedge clk);
      if (bus_a.done !== 1'b0 || bus_b.done !== 1'b0 ||
          bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) saw = 1;
    end
    check("no_result_after_abort", 32'(saw), 32'd0);
    prev_a = '{0, 0, 0};
    prev_b = '{0, 0, 0};

    fill_random();
    run_scan(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_analyzer_p.md
COLOR_ANALYZER_P -- requirements
Module: color_analyzer_p

Interface
REQ-001 Parameter AW, default 15: frame-buffer address width.
REQ-002 Parameter NPIX, default 19200: pixels per scan (160x120).
REQ-003 Parameter BASE_ADDR, default 0: first pixel address; BASE_ADDR+NPIX-1 SHALL fit in AW bits.
REQ-004 Parameter PARK_ADDR, default all-ones: address driven while not scanning.
REQ-005 Parameter MODE, default 0: pixel format; 0 = RGB332 (DW=8), 1 = RGB444 (DW=12).
REQ-006 Parameter RD_LAT, default 1 (range 1..4): cycles from addr to valid data.
REQ-007 Parameter MARGIN, default 0: minimum lead a channel sum needs to be declared dominant.
REQ-008 Parameter SW, default 20: accumulator width; SHALL hold NPIX*15 without overflow.
REQ-009 clk  in  1  single clock, all logic on rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 init  in  1  start request; rising edge (0 in previous cycle, 1 now) starts a scan.
REQ-012 data  in  DW  pixel read from frame buffer.
REQ-013 addr  out  AW  frame-buffer read address.
REQ-014 busy  out  1  high while a scan is in progress.
REQ-015 done  out  1  high from scan completion until next accepted start or reset.
REQ-016 valor  out  3  result {R,G,B}: 100 red, 010 green, 001 blue, 111 no dominant, 000 black.
REQ-017 sum_r, sum_g, sum_b  out  SW each  channel totals of last completed scan.

Function
REQ-018 States SHALL be IDLE, ISSUE, DRAIN, DECIDE; IDLE->ISSUE on accepted start, ISSUE->DRAIN after NPIX addresses, DRAIN->DECIDE after RD_LAT cycles, DECIDE->IDLE after one cycle.
REQ-019 Start edge SHALL be accepted only in IDLE; edges in any other state SHALL be ignored and never queued.
REQ-020 On accepted start: clear internal accumulators, done<=0, busy<=1; sum_*/valor keep previous values until DECIDE.
REQ-021 In ISSUE, addr SHALL run BASE_ADDR, BASE_ADDR+1, ... BASE_ADDR+NPIX-1, one per cycle, no gaps, no wrap.
REQ-022 A valid-tag pipeline RD_LAT deep SHALL mark which data cycles are accumulated; exactly NPIX samples per scan.
REQ-023 Channel extraction MODE 0: r=data[7:5], g=data[4:2], b={data[1:0],0}; MODE 1: r=data[11:8], g=data[7:4], b=data[3:0]; zero-extended to SW.
REQ-024 In DECIDE: sum_*<=accumulators; valor=000 if all three sums zero; else 100 if R>G+MARGIN and R>B+MARGIN; else 010 if G>R+MARGIN and G>B+MARGIN; else 001 if B>R+MARGIN and B>G+MARGIN; else 111; comparisons in SW+1 bits.
REQ-025 Ties or leads <= MARGIN SHALL yield 111.
REQ-026 Leaving DECIDE: done<=1, busy<=0, addr<=PARK_ADDR.
REQ-027 Latency: with start edge sampled at cycle 0, first address at cycle 1, done high at cycle NPIX+RD_LAT+2.
REQ-028 addr SHALL equal PARK_ADDR in IDLE.
REQ-029 init held high SHALL start only one scan; a new scan requires init low for >=1 cycle.

Reset
REQ-030 rst high SHALL, on the next edge, force IDLE, addr=PARK_ADDR, busy=0, done=0, valor=000, sum_*=0, accumulators=0, init history=0.
REQ-031 rst SHALL override every state, including mid-scan; the aborted scan produces no result.
REQ-032 rst and init both high in the same cycle: reset wins; the start is not accepted.

Verification
REQ-033 MODE0, NPIX=16, all pixels 8'hE0 -> sum_r=112, sum_g=0, sum_b=0, valor=100, done at cycle NPIX+RD_LAT+2.
REQ-034 MODE0, all pixels 8'h03 -> sum_b=96, valor=001; all 8'h1C -> valor=010; all 8'h00 -> valor=000.
REQ-035 MODE0, alternating 8'hE0/8'h1C, MARGIN=0 -> sum_r=sum_g=56, valor=111.
REQ-036 RD_LAT=3, ramp data -> exactly NPIX samples summed, addr sequence BASE..BASE+NPIX-1 then PARK_ADDR.
REQ-037 init re-pulsed mid-scan -> ignored, single done; rst at pixel 5 -> IDLE next cycle, all outputs zero, no done.
REQ-038 MODE1, all 12'hF00, MARGIN=10 -> valor=100; all 12'h880 -> valor=111.
